// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state type and constants for i2c_target (I2C_TARGET_STRETCH_EN adds STRETCH)
package i2c_pkg;

    localparam int unsigned FILTER_LEN_MAX = 15;
    localparam int unsigned FILTER_CNT_W   = $clog2(FILTER_LEN_MAX + 1);
    localparam int unsigned RW_BIT         = 0;
    localparam logic        ACK            = 1'b0;
    localparam logic        NACK           = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
`ifdef I2C_TARGET_STRETCH_EN
        , STRETCH
`endif
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - pad synchronizer plus run-length glitch filter with edge strobes
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rstN,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]              sync_ff;
    logic [FILTER_CNT_W-1:0] cnt;
    logic                    settle;

    // accept the synchronized level once it has differed for FILTER_LEN samples in a row
    assign settle = (sync_ff[1] != level) && (cnt == FILTER_CNT_W'(FILTER_LEN - 1));

    // synchronizer, run counter, filtered level and edge strobes aligned with the level change
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_ff <= 2'b11;
            level   <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_ff <= {sync_ff[0], pad};
            rise    <= settle & sync_ff[1];
            fall    <= settle & ~sync_ff[1];
            if (settle) begin
                level <= sync_ff[1];
                cnt   <= '0;
            end else if (sync_ff[1] == level) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + FILTER_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - single-address I2C target; I2C_TARGET_STRETCH_EN enables SCL stretching on reads
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h48,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sdaDriveLow,
    output logic       sclDriveLow,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReq,
    output logic       busy
);

    logic       scl, scl_rise, scl_fall;
    logic       sda, sda_rise, sda_fall;
    logic       start_det, stop_det;
    i2c_state_e state, state_nxt;
    logic [2:0] bit_cnt, cnt_nxt;
    logic [6:0] shreg;
    logic [7:0] shift_in;
    logic [7:0] tx_sh;
    logic       addr_match;
    logic       drive_nxt, busy_nxt, req_nxt;
    logic       shift_en, rx_load, tx_load, tx_shift;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (clk),
        .rstN  (rstN),
        .pad   (sclIn),
        .level (scl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (clk),
        .rstN  (rstN),
        .pad   (sdaIn),
        .level (sda),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det  = sda_fall & scl;
    assign stop_det   = sda_rise & scl;
    assign shift_in   = {shreg, sda};
    assign addr_match = (shift_in[7:1] == TARGET_ADDR);

    // next state and per-cycle datapath actions; START/STOP override any bit activity
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        drive_nxt = sdaDriveLow;
        busy_nxt  = busy;
        req_nxt   = 1'b0;
        shift_en  = 1'b0;
        rx_load   = 1'b0;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
        if (start_det) begin
            state_nxt = ADDR;
            cnt_nxt   = '0;
            drive_nxt = 1'b0;
        end else if (stop_det) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            drive_nxt = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: drive_nxt = 1'b0;
                ADDR: begin
                    if (scl_rise) begin
                        shift_en = 1'b1;
                        cnt_nxt  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            busy_nxt  = addr_match;
                            state_nxt = addr_match ? ADDR_ACK : IDLE;
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        drive_nxt = ~ACK;
                    end else if (scl_rise) begin
                        if (state == ADDR_ACK && shreg[RW_BIT]) begin
                            req_nxt   = 1'b1;
                            state_nxt = RD_DATA;
                        end else begin
                            state_nxt = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_fall) begin
                        drive_nxt = 1'b0;
                    end else if (scl_rise) begin
                        shift_en = 1'b1;
                        cnt_nxt  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_load   = 1'b1;
                            state_nxt = WR_ACK;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
`ifdef I2C_TARGET_STRETCH_EN
                            if (!txValid) begin
                                drive_nxt = 1'b0;
                                state_nxt = STRETCH;
                            end else
`endif
                            begin
                                tx_load   = 1'b1;
                                drive_nxt = ~txData[7];
                            end
                        end else begin
                            tx_shift  = 1'b1;
                            drive_nxt = ~tx_sh[7];
                        end
                    end else if (scl_rise) begin
                        cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = RD_ACK;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        drive_nxt = 1'b0;
                    end else if (scl_rise) begin
                        if (sda == NACK) begin
                            state_nxt = IDLE;
                        end else begin
                            req_nxt   = 1'b1;
                            state_nxt = RD_DATA;
                        end
                    end
                end
`ifdef I2C_TARGET_STRETCH_EN
                STRETCH: begin
                    if (txValid) begin
                        tx_load   = 1'b1;
                        drive_nxt = ~txData[7];
                        state_nxt = RD_DATA;
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    // state register and the registered datapath driven by the decisions above
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            tx_sh       <= '0;
            sdaDriveLow <= 1'b0;
            rxData      <= '0;
            rxValid     <= 1'b0;
            txReq       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= cnt_nxt;
            sdaDriveLow <= drive_nxt;
            busy        <= busy_nxt;
            txReq       <= req_nxt;
            rxValid     <= rx_load;
            if (shift_en) shreg <= shift_in[6:0];
            if (rx_load) rxData <= shift_in;
            if (tx_load) begin
                tx_sh <= {txData[6:0], 1'b0};
            end else if (tx_shift) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
        end
    end

`ifdef I2C_TARGET_STRETCH_EN
    // hold SCL while stretching; let go one cycle after the byte is latched, or at once on START/STOP
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sclDriveLow <= 1'b0;
        end else begin
            sclDriveLow <= (state_nxt == STRETCH) ||
                           (state == STRETCH && !start_det && !stop_det);
        end
    end
`else
    logic unused_tx_valid;
    assign unused_tx_valid = txValid;
    assign sclDriveLow     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bus-level bench for i2c_target (stretch test needs I2C_TARGET_STRETCH_EN)
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic       clk   = 1'b0;
    logic       rstN  = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_bus, sda_bus;
    logic       sdaDriveLow, sclDriveLow, rxValid, txReq, busy;
    logic       txValid = 1'b1;
    logic [7:0] txData  = 8'h00;
    logic [7:0] rxData;
    int         tests   = 0;
    int         fails   = 0;
    int         rx_cnt  = 0;
    int         req_cnt = 0;
    logic [7:0] rx_log [4];
    logic [7:0] tx_q   [4];
    logic       drove_sda = 1'b0;

    assign scl_bus = m_scl & ~sclDriveLow;
    assign sda_bus = m_sda & ~sdaDriveLow;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h48), .FILTER_LEN(4)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .sclIn       (scl_bus),
        .sdaIn       (sda_bus),
        .sdaDriveLow (sdaDriveLow),
        .sclDriveLow (sclDriveLow),
        .rxData      (rxData),
        .rxValid     (rxValid),
        .txData      (txData),
        .txValid     (txValid),
        .txReq       (txReq),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // user side: log received bytes, feed the next read byte on each request
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rxValid) begin
                if (rx_cnt < 4) rx_log[rx_cnt] = rxData;
                rx_cnt++;
            end
            if (txReq) begin
                if (req_cnt < 4) txData = tx_q[req_cnt];
                req_cnt++;
            end
            if (sdaDriveLow) drove_sda = 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_high();
        int n = 0;
        m_scl = 1'b1;
        while (scl_bus !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (scl_bus !== 1'b1) check("scl_release", 32'(scl_bus), 32'd1);
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        m_sda = b;
        cyc(Q);
        scl_high();
        cyc(Q);
        s = sda_bus;
        cyc(Q);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_start();
        if (m_scl == 1'b0) begin
            m_sda = 1'b1;
            cyc(Q);
            scl_high();
        end
        cyc(2 * Q);
        m_sda = 1'b0;
        cyc(2 * Q);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        cyc(Q);
        scl_high();
        cyc(2 * Q);
        m_sda = 1'b1;
        cyc(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, s);
            d = {d[6:0], s};
        end
        i2c_bit(mack, s);
    endtask

    initial begin
        logic       ack;
        logic       held;
        logic [7:0] d;

        cyc(3);
        check("rst_sda_drive", 32'(sdaDriveLow), 32'd0);
        check("rst_scl_drive", 32'(sclDriveLow), 32'd0);
        check("rst_rx_data",   32'(rxData),      32'd0);
        check("rst_rx_valid",  32'(rxValid),     32'd0);
        check("rst_tx_req",    32'(txReq),       32'd0);
        check("rst_busy",      32'(busy),        32'd0);
        rstN = 1'b1;
        cyc(20);

        // write 0x48+W, 0xA5, 0x3C, STOP
        rx_cnt = 0;
        i2c_start();
        write_byte(8'h90, ack);  check("t1_addr_ack", 32'(ack), 32'(ACK));
        write_byte(8'hA5, ack);  check("t1_d0_ack",   32'(ack), 32'(ACK));
        write_byte(8'h3C, ack);  check("t1_d1_ack",   32'(ack), 32'(ACK));
        check("t1_busy", 32'(busy), 32'd1);
        i2c_stop();
        check("t1_rx_count", 32'(rx_cnt),    32'd2);
        check("t1_rx0",      32'(rx_log[0]), 32'hA5);
        check("t1_rx1",      32'(rx_log[1]), 32'h3C);
        check("t1_busy_end", 32'(busy),      32'd0);
        cyc(20);

        // wrong address 0x49+W is ignored
        rx_cnt    = 0;
        drove_sda = 1'b0;
        i2c_start();
        write_byte(8'h92, ack);  check("t2_addr_nack", 32'(ack), 32'(NACK));
        write_byte(8'h00, ack);  check("t2_data_nack", 32'(ack), 32'(NACK));
        check("t2_busy", 32'(busy), 32'd0);
        i2c_stop();
        check("t2_never_drove", 32'(drove_sda), 32'd0);
        check("t2_rx_count",    32'(rx_cnt),    32'd0);
        cyc(20);

        // read 0x48+R: 0x5A (master ACK), 0xC3 (master NACK)
        req_cnt = 0;
        tx_q[0] = 8'h5A;
        tx_q[1] = 8'hC3;
        i2c_start();
        write_byte(8'h91, ack);  check("t3_addr_ack", 32'(ack), 32'(ACK));
        read_byte(ACK, d);       check("t3_byte0",    32'(d),   32'h5A);
        read_byte(NACK, d);      check("t3_byte1",    32'(d),   32'hC3);
        check("t3_req_count", 32'(req_cnt),   32'd2);
        check("t3_idle",      32'(dut.state), 32'(IDLE));
        i2c_stop();
        cyc(20);

        // write 0x11, repeated START, read 0x96 without STOP in between
        req_cnt = 0;
        tx_q[0] = 8'h96;
        i2c_start();
        write_byte(8'h90, ack);
        write_byte(8'h11, ack);  check("t4_d0_ack", 32'(ack), 32'(ACK));
        i2c_start();
        check("t4_rx_data", 32'(rxData), 32'h11);
        write_byte(8'h91, ack);  check("t4_raddr_ack", 32'(ack), 32'(ACK));
        read_byte(NACK, d);      check("t4_rd_byte",   32'(d),   32'h96);
        i2c_stop();
        cyc(20);

        // SCL glitch shorter than the filter, then reset mid-byte
        rx_cnt = 0;
        i2c_start();
        write_byte(8'h90, ack);
        for (int i = 7; i >= 4; i--) i2c_bit(d[0] ^ d[0] ^ 8'hA5 >> i & 1'b1, held);
        m_scl = 1'b1;
        cyc(3);
        m_scl = 1'b0;
        cyc(20);
        check("t5_glitch_cnt",  32'(dut.bit_cnt), 32'd4);
        check("t5_glitch_rx",   32'(rx_cnt),      32'd0);
        check("t5_busy_before", 32'(busy),        32'd1);
        rstN = 1'b0;
        cyc(1);
        check("t5_rst_rx_data", 32'(rxData),      32'd0);
        check("t5_rst_busy",    32'(busy),        32'd0);
        check("t5_rst_sda",     32'(sdaDriveLow), 32'd0);
        check("t5_rst_state",   32'(dut.state),   32'(IDLE));
        rstN = 1'b1;
        cyc(10);
        i2c_start();
        write_byte(8'h90, ack);  check("t5_addr_ack_after_rst", 32'(ack), 32'(ACK));
        i2c_stop();
        cyc(20);

`ifdef I2C_TARGET_STRETCH_EN
        // read with txValid low for 500 cycles: SCL held, released one cycle after txValid
        req_cnt = 0;
        tx_q[0] = 8'h3C;
        txValid = 1'b0;
        i2c_start();
        write_byte(8'h91, ack);  check("t6_addr_ack", 32'(ack), 32'(ACK));
        fork
            read_byte(NACK, d);
            begin
                for (int n = 0; n < 400 && !sclDriveLow; n++) begin
                    @(posedge clk);
                    #1;
                end
                held = sclDriveLow;
                repeat (500) begin
                    @(posedge clk);
                    #1;
                    held = held & sclDriveLow;
                end
                check("t6_stretch_hold", 32'(held), 32'd1);
                @(negedge clk);
                txValid = 1'b1;
                @(posedge clk);
                #1;
                check("t6_release_lag", 32'(sclDriveLow), 32'd1);
                @(posedge clk);
                #1;
                check("t6_released", 32'(sclDriveLow), 32'd0);
            end
        join
        check("t6_byte", 32'(d), 32'h3C);
        i2c_stop();
        cyc(20);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) that answers a single 7-bit address on the bus driven by the team's `i2c` byte-level master engine. It oversamples SCL and SDA on the system clock, detects START and STOP, and ACKs its own address. Write bytes go to the user as `rxData`/`rxValid`; read bytes are requested with `txReq` and shifted out on SDA. Both lines are open-drain: the block only ever drives a line low.

## Interface
- `TARGET_ADDR`, default 7'h48: 7-bit address this target responds to.
- `FILTER_LEN`, default 4: consecutive equal synchronized samples needed to accept a line change (range 1–15).
- `clk` in 1: system clock; all logic is on its rising edge.
- `rstN` in 1: asynchronous active-low reset.
- `sclIn` in 1: raw SCL pad input.
- `sdaIn` in 1: raw SDA pad input.
- `sdaDriveLow` out 1: 1 pulls SDA low; 0 releases it.
- `sclDriveLow` out 1: 1 holds SCL low for clock stretching; constant 0 unless the stretch macro is defined.
- `rxData` out 8: last byte received in a write transfer, MSB first.
- `rxValid` out 1: one-cycle pulse when `rxData` updates.
- `txData` in 8: next byte to transmit in a read transfer.
- `txValid` in 1: `txData` is ready; used only with the stretch macro.
- `txReq` out 1: one-cycle pulse asking for the next `txData`.
- `busy` out 1: high from address match until STOP or a non-matching repeated START.

## Operation
- **Input conditioning:** 2-flop synchronizer, then a filter. Filtered `scl`/`sda` change only after `FILTER_LEN` consecutive equal samples.
- **Events, from filtered lines only:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rise: sample SDA.
  - SCL fall: update `sdaDriveLow`.
- **States:** IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, plus STRETCH when the macro is defined.
- **Transitions:**
  - START from any state → ADDR; bit counter cleared.
  - STOP from any state → IDLE; SDA released; `busy` cleared.
  - ADDR: shift 8 bits. If `addr[7:1]` == `TARGET_ADDR`, go to ADDR_ACK and drive SDA low for the 9th clock. Otherwise go to IDLE, never drive SDA, and ignore the bus until the next START.
  - After ADDR_ACK: R/W=0 → WR_DATA; R/W=1 → RD_DATA.
  - WR_DATA: on the 8th SCL rise, update `rxData` and pulse `rxValid` once. WR_ACK then drives ACK (low) for the 9th clock. Loop back to WR_DATA.
  - RD_DATA: `txReq` pulses at the SCL rise of the preceding ACK bit (address ACK or master ACK). `txData` is latched at the following SCL fall, and its MSB is driven on that same fall.
  - RD_ACK: SDA released; master ACK (0) → RD_DATA; master NACK (1) → IDLE, waiting for STOP or START.
- **Drive rule:** SDA is driven only for 0-bits and ACK. A 1-bit always means released.
- **Reset mid-transfer:** all outputs go to reset values immediately; the FSM restarts in IDLE and waits for a START.

## Timing
- **Reset values:** `sdaDriveLow`=0, `sclDriveLow`=0, `rxData`=0, `rxValid`=0, `txReq`=0, `busy`=0, state IDLE.
- **Input latency:** pad to filtered line is 2 + `FILTER_LEN` cycles.
- **SDA output:** `sdaDriveLow` changes 1 cycle after a filtered SCL fall. SCL low time must exceed (2 + `FILTER_LEN` + 2) `clk` periods.
- **Simultaneous events:** START/STOP take priority over bit sampling in the same cycle.
- **Wrap-around:** the bit counter wraps 8→0 at each ACK.
- **`rxValid` spacing:** at least 9 SCL periods apart.
- **Read hand-off without stretch:** `txData` must be stable from the `txReq` pulse until the next filtered SCL fall (half an SCL period).

## Configuration
- Macro `I2C_TARGET_STRETCH_EN`.
- **Defined:** on the SCL fall where `txData` would be latched, if `txValid`=0, enter STRETCH and assert `sclDriveLow`. When `txValid`=1, latch `txData`, drive its MSB, then release SCL 1 cycle later. START/STOP inside STRETCH releases SCL.
- **Undefined:** no STRETCH state; `txValid` is ignored; `sclDriveLow` is tied 0.

## Structure
- **Package `i2c_pkg`:** state enum, the `FILTER_LEN` limit constant, the R/W bit index, and ACK/NACK constants.
- **Sub-module `i2c_line_filter`:** one instance per line. Contains the synchronizer and the `FILTER_LEN` counter filter. Outputs the filtered level plus one-cycle rise and fall strobes.

## Test plan
- Master writes addr 0x48+W, then 0xA5, 0x3C, then STOP → ACK on all 3 bytes; `rxValid` pulses twice with `rxData` 0xA5 then 0x3C; `busy` falls on STOP.
- Master addresses 0x49+W → SDA never driven, no `rxValid`, `busy`=0.
- Read 0x48+R with `txData` 0x5A then 0xC3; master ACKs, then NACKs → bus bits 01011010, 11000011; exactly 2 `txReq` pulses; state IDLE after NACK.
- Write 0x11, repeated START, read → `rxData`=0x11, then the read byte is driven correctly with no STOP in between.
- Glitch on SCL for `FILTER_LEN`-1 cycles mid-byte, then `rstN` pulsed low mid-byte → glitch ignored (bit count unchanged); after reset all outputs are 0 and the next START+0x48 is ACKed.
- With `I2C_TARGET_STRETCH_EN`, read while holding `txValid`=0 for 500 cycles → `sclDriveLow`=1 throughout; released 1 cycle after `txValid` rises; byte correct.
